// File: rtl/stim_cmd_builder.sv
// stim_cmd_builder: snapshots the stim sequencer vectors once per frame and emits RHS2116
// register-write commands for changed fields into three auxiliary SPI command slots.
`default_nettype none

module stim_cmd_builder #(
    parameter logic [7:0]  REG_STIM_ON    = 8'd42,
    parameter logic [7:0]  REG_STIM_POL   = 8'd44,
    parameter logic [7:0]  REG_CHRG_RECOV = 8'd46,
    parameter logic [5:0]  FIRST_SLOT     = 6'd16,
    parameter logic [31:0] SNAP_STATE     = 32'd99,
    parameter logic [31:0] EMIT_STATE     = 32'd100
) (
    input  logic        dataclk,
    input  logic        reset,
    input  logic [31:0] main_state,
    input  logic [5:0]  channel,
    input  logic [15:0] stim_on,
    input  logic [15:0] stim_pol,
    input  logic [15:0] charge_recov,
    input  logic [15:0] amp_settle,
    input  logic        amp_settle_changed,
    input  logic        stim_cmd_en,
    input  logic        reset_sequencer,
    output logic [31:0] cmd_word,
    output logic        cmd_strobe,
    output logic [15:0] settle_flags,
    output logic        settle_update
);

    // Dummy read of register 255: keeps the aux slot busy without side effects.
    localparam logic [31:0] IDLE_WORD = {2'b11, 1'b0, 1'b0, 4'b0000, 8'hFF, 16'h0000};

    typedef enum logic [1:0] {
        KIND_IDLE = 2'd0,
        KIND_POL  = 2'd1,
        KIND_ON   = 2'd2,
        KIND_CR   = 2'd3
    } kind_t;

    logic [15:0] last_on_q;
    logic [15:0] last_pol_q;
    logic [15:0] last_cr_q;
    logic        force_all_q;
    logic        en_snap_q;
    kind_t       slot_kind_q [0:2];
    logic [15:0] slot_data_q [0:2];
    logic [2:0]  slot_u_q;
    logic [31:0] cmd_word_q;
    logic        cmd_strobe_q;
    logic [15:0] settle_flags_q;
    logic        settle_update_q;

    kind_t       slot_kind_d [0:2];
    logic [15:0] slot_data_d [0:2];
    logic [2:0]  slot_u_d;
    logic [1:0]  slot_cnt_d;

    logic        snap_hit;
    logic        snap_en;
    logic        pend_pol;
    logic        pend_on;
    logic        pend_cr;

    logic [5:0]  emit_off;
    logic        emit_hit;
    logic [1:0]  emit_k;
    kind_t       emit_kind;
    logic [15:0] emit_data;
    logic        emit_u;
    logic [7:0]  emit_reg;
    logic [31:0] emit_word;

    assign snap_hit = (channel == FIRST_SLOT) && (main_state == SNAP_STATE);
    assign snap_en  = stim_cmd_en && !reset_sequencer;
    assign pend_pol = snap_en && (force_all_q || (stim_pol     != last_pol_q));
    assign pend_on  = snap_en && (force_all_q || (stim_on      != last_on_q));
    assign pend_cr  = snap_en && (force_all_q || (charge_recov != last_cr_q));

    // Compact pending writes in fixed POL, ON, CR order; U marks the last real write.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            slot_kind_d[i] = KIND_IDLE;
            slot_data_d[i] = 16'h0000;
        end
        slot_u_d   = 3'b000;
        slot_cnt_d = 2'd0;
        if (pend_pol) begin
            slot_kind_d[slot_cnt_d] = KIND_POL;
            slot_data_d[slot_cnt_d] = stim_pol;
            slot_cnt_d              = slot_cnt_d + 2'd1;
        end
        if (pend_on) begin
            slot_kind_d[slot_cnt_d] = KIND_ON;
            slot_data_d[slot_cnt_d] = stim_on;
            slot_cnt_d              = slot_cnt_d + 2'd1;
        end
        if (pend_cr) begin
            slot_kind_d[slot_cnt_d] = KIND_CR;
            slot_data_d[slot_cnt_d] = charge_recov;
            slot_cnt_d              = slot_cnt_d + 2'd1;
        end
        if (slot_cnt_d != 2'd0) begin
            slot_u_d[slot_cnt_d - 2'd1] = 1'b1;
        end
    end

    assign emit_off = channel - FIRST_SLOT;
    assign emit_hit = (main_state == EMIT_STATE) && (channel >= FIRST_SLOT) && (emit_off < 6'd3);
    assign emit_k   = emit_off[1:0];

    always_comb begin
        emit_kind = slot_kind_q[2];
        emit_data = slot_data_q[2];
        emit_u    = slot_u_q[2];
        case (emit_k)
            2'd0: begin
                emit_kind = slot_kind_q[0];
                emit_data = slot_data_q[0];
                emit_u    = slot_u_q[0];
            end
            2'd1: begin
                emit_kind = slot_kind_q[1];
                emit_data = slot_data_q[1];
                emit_u    = slot_u_q[1];
            end
            default: ;
        endcase
    end

    always_comb begin
        emit_reg = 8'hFF;
        case (emit_kind)
            KIND_POL: emit_reg = REG_STIM_POL;
            KIND_ON:  emit_reg = REG_STIM_ON;
            KIND_CR:  emit_reg = REG_CHRG_RECOV;
            default:  emit_reg = 8'hFF;
        endcase
        if (emit_kind == KIND_IDLE) begin
            emit_word = IDLE_WORD;
        end else begin
            emit_word = {2'b10, emit_u, 1'b0, 4'b0000, emit_reg, emit_data};
        end
    end

    always_ff @(posedge dataclk) begin
        if (reset) begin
            last_on_q       <= 16'h0000;
            last_pol_q      <= 16'h0000;
            last_cr_q       <= 16'h0000;
            force_all_q     <= 1'b1;
            en_snap_q       <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                slot_kind_q[i] <= KIND_IDLE;
                slot_data_q[i] <= 16'h0000;
            end
            slot_u_q        <= 3'b000;
            cmd_word_q      <= IDLE_WORD;
            cmd_strobe_q    <= 1'b0;
            settle_flags_q  <= 16'h0000;
            settle_update_q <= 1'b0;
        end else begin
            cmd_strobe_q <= 1'b0;

            if (snap_hit) begin
                for (int i = 0; i < 3; i++) begin
                    slot_kind_q[i] <= slot_kind_d[i];
                    slot_data_q[i] <= slot_data_d[i];
                end
                slot_u_q  <= slot_u_d;
                en_snap_q <= snap_en;
                // A disabled or soft-reset frame must cause a full resend once enabled again.
                if (!snap_en) begin
                    force_all_q <= 1'b1;
                end
                if (amp_settle_changed) begin
                    settle_flags_q  <= amp_settle;
                    settle_update_q <= 1'b1;
                end else begin
                    settle_update_q <= 1'b0;
                end
            end

            if (emit_hit) begin
                cmd_word_q   <= emit_word;
                cmd_strobe_q <= 1'b1;
                case (emit_kind)
                    KIND_POL: last_pol_q <= emit_data;
                    KIND_ON:  last_on_q  <= emit_data;
                    KIND_CR:  last_cr_q  <= emit_data;
                    default:  ;
                endcase
                if ((emit_k == 2'd2) && en_snap_q) begin
                    force_all_q <= 1'b0;
                end
            end
        end
    end

    assign cmd_word      = cmd_word_q;
    assign cmd_strobe    = cmd_strobe_q;
    assign settle_flags  = settle_flags_q;
    assign settle_update = settle_update_q;

endmodule

`default_nettype wire

// File: tb/tb_stim_cmd_builder.sv
// tb_stim_cmd_builder: frame-level scoreboard bench for stim_cmd_builder.
`default_nettype none

module tb_stim_cmd_builder;

    localparam logic [31:0] IDLE = 32'hC0FF0000;

    logic        dataclk = 1'b0;
    logic        reset;
    logic [31:0] main_state;
    logic [5:0]  channel;
    logic [15:0] stim_on;
    logic [15:0] stim_pol;
    logic [15:0] charge_recov;
    logic [15:0] amp_settle;
    logic        amp_settle_changed;
    logic        stim_cmd_en;
    logic        reset_sequencer;
    logic [31:0] cmd_word;
    logic        cmd_strobe;
    logic [15:0] settle_flags;
    logic        settle_update;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_q[$];

    always #5 dataclk = ~dataclk;

    stim_cmd_builder dut (
        .dataclk            (dataclk),
        .reset              (reset),
        .main_state         (main_state),
        .channel            (channel),
        .stim_on            (stim_on),
        .stim_pol           (stim_pol),
        .charge_recov       (charge_recov),
        .amp_settle         (amp_settle),
        .amp_settle_changed (amp_settle_changed),
        .stim_cmd_en        (stim_cmd_en),
        .reset_sequencer    (reset_sequencer),
        .cmd_word           (cmd_word),
        .cmd_strobe         (cmd_strobe),
        .settle_flags       (settle_flags),
        .settle_update      (settle_update)
    );

    // One SPI frame: channels 0..19, four main_state values per channel.
    // Optional one-cycle reset at (rst_ch, state 98).
    task automatic run_frame(input string name, input int rst_ch);
        int          n_strobe = 0;
        logic [31:0] exp_w;
        logic [31:0] last_w = IDLE;
        for (int ch = 0; ch < 20; ch++) begin
            for (int st = 98; st < 102; st++) begin
                @(negedge dataclk);
                channel    = 6'(ch);
                main_state = 32'(st);
                reset      = (ch == rst_ch) && (st == 98);
                @(posedge dataclk);
                #1;
                if (cmd_strobe === 1'b1) begin
                    n_strobe++;
                    n_total++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL %s unexpected strobe ch=%0d st=%0d word=%h", name, ch, st, cmd_word);
                    end else begin
                        exp_w  = exp_q.pop_front();
                        last_w = exp_w;
                        if (cmd_word !== exp_w) begin
                            n_bad++;
                            $display("FAIL %s slot word ch=%0d got=%h exp=%h", name, ch, cmd_word, exp_w);
                        end
                    end
                end
            end
        end
        @(negedge dataclk);
        reset = 1'b0;
        n_total++;
        if (n_strobe !== 3 || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL %s strobe count got=%0d exp=3 leftover=%0d", name, n_strobe, exp_q.size());
            exp_q.delete();
        end
        n_total++;
        if (cmd_word !== last_w) begin
            n_bad++;
            $display("FAIL %s cmd_word hold got=%h exp=%h", name, cmd_word, last_w);
        end
    endtask

    task automatic push3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge dataclk);
        #1;
        n_total++;
        if (cmd_word !== IDLE) begin
            n_bad++;
            $display("FAIL reset cmd_word got=%h exp=%h", cmd_word, IDLE);
        end
        n_total++;
        if (cmd_strobe !== 1'b0 || settle_update !== 1'b0) begin
            n_bad++;
            $display("FAIL reset strobe/update got=%b%b exp=00", cmd_strobe, settle_update);
        end
        n_total++;
        if (settle_flags !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset settle_flags got=%h exp=0000", settle_flags);
        end
        @(negedge dataclk);
        reset = 1'b0;
    endtask

    task automatic test_force_all();
        stim_cmd_en = 1'b1;
        push3(32'h802C0000, 32'h802A0000, 32'hA02E0000);
        run_frame("force_all", -1);
        push3(IDLE, IDLE, IDLE);
        run_frame("no_change", -1);
    endtask

    task automatic test_single_change();
        stim_on = 16'h0005;
        push3(32'hA02A0005, IDLE, IDLE);
        run_frame("on_only", -1);
        push3(IDLE, IDLE, IDLE);
        run_frame("on_settled", -1);
    endtask

    task automatic test_two_changes();
        stim_pol     = 16'h8000;
        charge_recov = 16'h0001;
        push3(32'h802C8000, 32'hA02E0001, IDLE);
        run_frame("pol_cr", -1);
    endtask

    task automatic test_disable();
        stim_cmd_en = 1'b0;
        stim_on     = 16'h0003;
        push3(IDLE, IDLE, IDLE);
        run_frame("disabled", -1);
        stim_cmd_en = 1'b1;
        push3(32'h802C8000, 32'h802A0003, 32'hA02E0001);
        run_frame("reenabled", -1);
    endtask

    task automatic test_settle();
        amp_settle         = 16'h00F0;
        amp_settle_changed = 1'b1;
        push3(IDLE, IDLE, IDLE);
        run_frame("settle_chg", -1);
        n_total++;
        if (settle_flags !== 16'h00F0 || settle_update !== 1'b1) begin
            n_bad++;
            $display("FAIL settle_set got=%h/%b exp=00f0/1", settle_flags, settle_update);
        end
        amp_settle_changed = 1'b0;
        amp_settle         = 16'h0F0F;
        push3(IDLE, IDLE, IDLE);
        run_frame("settle_hold", -1);
        n_total++;
        if (settle_flags !== 16'h00F0 || settle_update !== 1'b0) begin
            n_bad++;
            $display("FAIL settle_hold got=%h/%b exp=00f0/0", settle_flags, settle_update);
        end
    endtask

    task automatic test_reset_sequencer();
        reset_sequencer = 1'b1;
        push3(IDLE, IDLE, IDLE);
        run_frame("seq_reset", -1);
        reset_sequencer = 1'b0;
        push3(32'h802C8000, 32'h802A0003, 32'hA02E0001);
        run_frame("after_seq_reset", -1);
    endtask

    task automatic test_mid_frame_reset();
        stim_on = 16'h0007;
        push3(32'hA02A0007, IDLE, IDLE);
        run_frame("mid_reset", 17);
        n_total++;
        if (settle_flags !== 16'h0000) begin
            n_bad++;
            $display("FAIL mid_reset settle_flags got=%h exp=0000", settle_flags);
        end
        push3(32'h802C8000, 32'h802A0007, 32'hA02E0001);
        run_frame("post_reset_resend", -1);
        push3(IDLE, IDLE, IDLE);
        run_frame("post_reset_idle", -1);
    endtask

    initial begin
        reset              = 1'b1;
        main_state         = 32'd0;
        channel            = 6'd0;
        stim_on            = 16'h0000;
        stim_pol           = 16'h0000;
        charge_recov       = 16'h0000;
        amp_settle         = 16'h0000;
        amp_settle_changed = 1'b0;
        stim_cmd_en        = 1'b0;
        reset_sequencer    = 1'b0;

        test_reset();
        test_force_all();
        test_single_change();
        test_two_changes();
        test_disable();
        test_settle();
        test_reset_sequencer();
        test_mid_frame_reset();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
